// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: IDLE -> ACCESS -> (RESP) -> IDLE.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester A has fixed priority.
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_sel_b;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_a_rdata, r_b_rdata;
  logic                  w_win_b;
  logic                  w_err;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last_b;

  // On a tie the requester not served last wins; error grants also move the pointer.
  assign w_win_b = b_req & (~a_req | ~r_last_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_last_b <= 1'b1;
    else if (r_state == S_ACCESS) r_last_b <= r_sel_b;
  end
`else
  assign w_win_b = b_req & ~a_req;
`endif

  assign w_err = (r_addr[1:0] != 2'b00) ||
                 ((r_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (a_req | b_req) w_next = S_ACCESS;
      S_ACCESS: w_next = (r_we | w_err) ? S_IDLE : S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    a_gnt         = 1'b0;
    b_gnt         = 1'b0;
    a_err         = 1'b0;
    b_err         = 1'b0;
    a_rvalid      = 1'b0;
    b_rvalid      = 1'b0;
    mem_addr      = '0;
    mem_writeData = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    case (r_state)
      S_ACCESS: begin
        a_gnt         = ~r_sel_b;
        b_gnt         = r_sel_b;
        a_err         = w_err & ~r_sel_b;
        b_err         = w_err & r_sel_b;
        mem_addr      = r_addr;
        mem_writeData = r_wdata;
        mem_write     = r_we & ~w_err;
        mem_read      = ~r_we & ~w_err;
      end
      S_RESP: begin
        a_rvalid = ~r_sel_b;
        b_rvalid = r_sel_b;
      end
      default: ;
    endcase
  end

  // Request fields are latched at arbitration so requesters may drop req once granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_b   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && (a_req | b_req)) begin
        r_sel_b <= w_win_b;
        r_we    <= w_win_b ? b_we    : a_we;
        r_addr  <= w_win_b ? b_addr  : a_addr;
        r_wdata <= w_win_b ? b_wdata : a_wdata;
      end
      if (r_state == S_ACCESS && !r_we && !w_err) begin
        if (r_sel_b) r_b_rdata <= mem_readData;
        else         r_a_rdata <= mem_readData;
      end
    end
  end

  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule
